// File: rtl/demux_1_n_transfer.sv
// Gather buffer: distributes a serial stream of signed transfer words into
// LEN_TRANSFER registered lanes and holds the full frame until released.
module demux_1_n_transfer #(
    parameter int I_WIDTH            = 8,
    parameter int F_WIDTH            = 8,
    parameter int LEN_TRANSFER       = 10,
    parameter int MAX_LEN_TRANSFER   = 10,
    parameter int SEL_DEMUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic signed [I_WIDTH+F_WIDTH-1:0]    tr_data_i,
    input  logic                                 tr_vld_i,
    output logic                                 tr_rdy_o,
    input  logic [SEL_DEMUX_TR_WIDTH-1:0]        sel_demux_tr_i,
    input  logic                                 sel_demux_tr_ld_i,
    input  logic                                 sel_demux_tr_rst_i,
    input  logic                                 release_i,
    output logic [SEL_DEMUX_TR_WIDTH-1:0]        sel_demux_tr_o,
    output logic signed [I_WIDTH+F_WIDTH-1:0]    tr_data_o [0:LEN_TRANSFER-1],
    output logic [LEN_TRANSFER-1:0]              lane_vld_o,
    output logic                                 full_o,
    output logic                                 done_o,
    output logic                                 err_o
);

    localparam logic [SEL_DEMUX_TR_WIDTH-1:0] LAST_LANE = SEL_DEMUX_TR_WIDTH'(LEN_TRANSFER - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                  state;
    logic                    accept;
    logic                    ld_ok;
    logic                    frame_done;
    logic [LEN_TRANSFER-1:0] wr_onehot;

    assign tr_rdy_o = (state == FILL);
    assign accept   = tr_vld_i & tr_rdy_o;
    assign ld_ok    = (sel_demux_tr_i <= LAST_LANE);

    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < LEN_TRANSFER; i++) begin
            if (sel_demux_tr_o == SEL_DEMUX_TR_WIDTH'(i)) wr_onehot[i] = 1'b1;
        end
    end

    // A frame completes when this accept fills the last missing lane; a
    // simultaneous release drops the word, so it can never complete a frame.
    assign frame_done = accept & ~release_i & (&(lane_vld_o | wr_onehot));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= FILL;
            sel_demux_tr_o <= '0;
            lane_vld_o     <= '0;
            full_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            for (int i = 0; i < LEN_TRANSFER; i++) tr_data_o[i] <= '0;
        end else begin
            done_o <= 1'b0;
            if (release_i) begin
                // Lane data is deliberately kept; only the bookkeeping clears.
                state          <= FILL;
                sel_demux_tr_o <= '0;
                lane_vld_o     <= '0;
                full_o         <= 1'b0;
                err_o          <= 1'b0;
            end else begin
                if (accept) begin
                    for (int i = 0; i < LEN_TRANSFER; i++) begin
                        if (wr_onehot[i]) tr_data_o[i] <= tr_data_i;
                    end
                    lane_vld_o <= lane_vld_o | wr_onehot;
                end
                if (frame_done) begin
                    state  <= HOLD;
                    full_o <= 1'b1;
                    done_o <= 1'b1;
                end
                // The write above used the old pointer; load/clear beat the increment.
                if (sel_demux_tr_rst_i) begin
                    sel_demux_tr_o <= '0;
                end else if (sel_demux_tr_ld_i && ld_ok) begin
                    sel_demux_tr_o <= sel_demux_tr_i;
                end else if (sel_demux_tr_ld_i) begin
                    err_o <= 1'b1;
                end else if (accept) begin
                    sel_demux_tr_o <= (sel_demux_tr_o == LAST_LANE) ? '0 : sel_demux_tr_o + 1'b1;
                end
            end
        end
    end

endmodule
